// File: rtl/mul_seq.sv
// Sequential shift-add multiplier. Each clock consumes one multiplier bit, and
// after LEN clocks Y holds the low LEN bits of A*B.
module mul_seq #(
  parameter int LEN = 16
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic [LEN-1:0] A,
  input  logic [LEN-1:0] B,
  output logic           DONE,
  output logic [LEN-1:0] Y
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t         r_state,  w_state_nxt;
  logic [LEN-1:0] r_mcand,  w_mcand_nxt;
  logic [LEN-1:0] r_mplier, w_mplier_nxt;
  logic [LEN-1:0] r_acc,    w_acc_nxt;
  logic [CW-1:0]  r_cnt,    w_cnt_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // START wins from every state, so a launch during BUSY aborts the running
  // operation. A and B are looked at only on that edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    if (START) begin
      w_state_nxt  = BUSY;
      w_mcand_nxt  = A;
      w_mplier_nxt = B;
      w_acc_nxt    = '0;
      w_cnt_nxt    = CW'(LEN);
    end else begin
      case (r_state)
        BUSY: begin
          if (r_mplier[0])
            w_acc_nxt = r_acc + r_mcand;
          w_mcand_nxt  = r_mcand << 1;
          w_mplier_nxt = r_mplier >> 1;
          w_cnt_nxt    = r_cnt - CW'(1);
          // Fixed latency: finish on the LEN-th edge, even when the rest of the
          // multiplier is zero.
          if (r_cnt == CW'(1))
            w_state_nxt = DONE_ST;
        end
        default: ;
      endcase
    end
  end

  assign DONE = (r_state == DONE_ST);
  assign Y    = r_acc;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and random bench for mul_seq. A reference product, computed with
// plain arithmetic, is compared against the latency, the DONE protocol and Y.
module tb_mul_seq;
  localparam int LEN = 16;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b1;
  logic           START = 1'b0;
  logic [LEN-1:0] A = '0;
  logic [LEN-1:0] B = '0;
  logic           DONE;
  logic [LEN-1:0] Y;

  int vectors = 0;
  int miscompares = 0;

  mul_seq #(.LEN(LEN)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .DONE(DONE), .Y(Y)
  );

  always #5 CLK = ~CLK;

  function automatic logic [LEN-1:0] ref_prod(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[LEN-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle START. A and B are returned to X once the sampling edge has passed.
  task automatic launch(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    @(negedge CLK);
    START = 1'b1; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0; A = 'x; B = 'x;
    check("done_low_after_start", 32'(DONE), 32'd0);
  endtask

  // Counts edges until DONE is seen, up to a fixed bound.
  task automatic wait_done(input int max, output int edges);
    edges = 0;
    while (edges < max) begin
      @(posedge CLK); #1;
      edges++;
      if (DONE === 1'b1) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int e;
    launch(a, b);
    wait_done(LEN + 4, e);
    check({tag, "_latency"}, 32'(e), 32'(LEN));
    check({tag, "_done"}, 32'(DONE), 32'd1);
    check({tag, "_y"}, 32'(Y), 32'(ref_prod(a, b)));
  endtask

  initial begin
    int e;
    logic [LEN-1:0] ra, rb;

    // Reset state
    #3 RST_N = 1'b0;
    #1;
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_y", 32'(Y), 32'd0);
    @(negedge CLK); RST_N = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      check("idle_done", 32'(DONE), 32'd0);
    end

    // Basic operation, followed by holding the result
    run_op("basic", 16'h00C1, 16'h0607);
    check("basic_const", 32'(Y), 32'h8B47);
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      check("hold_done", 32'(DONE), 32'd1);
      check("hold_y", 32'(Y), 32'h8B47);
    end

    // Zero and overflow corners
    run_op("zero", 16'h0000, 16'h1234);
    run_op("allones", 16'hFFFF, 16'hFFFF);
    check("allones_const", 32'(Y), 32'h0001);
    run_op("msb", 16'h8000, 16'h0002);
    check("msb_const", 32'(Y), 32'h0000);

    // Back-to-back sweep
    for (int i = 0; i < 100; i++)
      run_op("sweep", LEN'(i * 193), LEN'(i * 1543));

    // Random operands
    for (int i = 0; i < 40; i++) begin
      ra = LEN'($urandom);
      rb = LEN'($urandom);
      run_op("rand", ra, rb);
    end

    // A restart during BUSY must suppress the first operation's DONE
    launch(16'd3, 16'd5);
    repeat (3) begin
      @(posedge CLK); #1;
      check("restart_busy", 32'(DONE), 32'd0);
    end
    run_op("restart", 16'd7, 16'd9);
    check("restart_const", 32'(Y), 32'h003F);

    // Random aborts: the result must follow the last START only
    for (int i = 0; i < 10; i++) begin
      launch(LEN'($urandom), LEN'($urandom));
      repeat ($urandom_range(0, LEN - 2)) @(posedge CLK);
      ra = LEN'($urandom);
      rb = LEN'($urandom);
      run_op("abort", ra, rb);
    end

    // Asynchronous reset in the middle of an operation
    launch(16'hFFFF, 16'hFFFF);
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("midreset_done", 32'(DONE), 32'd0);
    check("midreset_y", 32'(Y), 32'd0);
    @(negedge CLK); RST_N = 1'b1;
    wait_done(LEN + 4, e);
    check("post_reset_no_done", 32'(DONE), 32'd0);
    check("post_reset_y", 32'(Y), 32'd0);

    run_op("after_reset", 16'h00C1, 16'h0607);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential shift-add integer multiplier. It computes the low LEN bits of A*B one multiplier bit per clock.
- Single-cycle START pulse launches an operation. DONE flags that Y holds a valid result.
- Used as a small area-efficient arithmetic unit where a combinational LEN×LEN multiplier is too large.

Parameters:
- LEN, 16, operand and result width in bits. Legal range is 2 or more.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  launch pulse; A and B are sampled on the same edge
- A  input  LEN  multiplicand; valid only in the START cycle
- B  input  LEN  multiplier; valid only in the START cycle
- DONE  output  1  result valid; stays high until the next START or reset
- Y  output  LEN  product, modulo 2^LEN

Behaviour:
- Reset: asynchronous, active-low (RST_N=0), from any state.
  - DONE=0, Y=0, internal state IDLE, counter=0, operand registers=0.
  - Leaving reset is synchronous to the next CLK edge.
- States: IDLE (DONE=0, no operation run yet), BUSY, DONE_ST (DONE=1).
- Launch: on any rising edge with START=1, from any state including BUSY.
  - Latch A into the multiplicand register and B into the multiplier register.
  - Clear the accumulator (Y=0), set counter=LEN, enter BUSY, DONE=0.
  - A START during BUSY aborts the current operation and restarts with the new operands.
- A and B are don't-care (may be X) in every cycle except the START cycle. They must never be sampled outside it.
- BUSY, each edge with START=0:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator, mod 2^LEN.
  - Shift the multiplicand left by 1 and the multiplier right by 1. Decrement the counter.
  - When the counter reaches 0, go to DONE_ST and set DONE=1.
- Latency is fixed: if START is sampled on edge E0, DONE rises exactly on edge E_LEN (16 edges for LEN=16). There is no early termination.
- DONE_ST:
  - DONE=1 and Y=product are held indefinitely.
  - START=0 keeps the state. START=1 relaunches and DONE drops on that same edge.
- Y is the accumulator register. It is only meaningful while DONE=1. During BUSY it shows partial sums.
- Arithmetic: unsigned. Y = (A*B) mod 2^LEN. Since the truncated product is sign-agnostic, the result is also correct for two's-complement operands.
- Outputs are registered only, with no combinational path from inputs to DONE or Y.
- START held high for several cycles restarts the operation every cycle. The operands latched are those on the last START edge.

Test Plan:
- Reset: RST_N=0 asynchronously mid-operation -> DONE=0 and Y=0 immediately. After release with no START, DONE stays 0.
- Basic: A=0x00C1, B=0x0607, START for 1 cycle, then A/B=X -> DONE rises exactly 16 edges after the START edge, Y=0x8B47.
- Zero and overflow:
  - A=0, B=0x1234 -> Y=0x0000.
  - A=0xFFFF, B=0xFFFF -> Y=0x0001.
  - A=0x8000, B=0x0002 -> Y=0x0000.
- Sweep: for i=0..99, A=(i*193) mod 2^16 and B=(i*1543) mod 2^16, back-to-back. Each new START is issued the cycle after DONE is seen.
  - Y equals (A*B) mod 2^16.
  - DONE=0 on the edge after each START.
  - DONE returns within 16 edges.
- Restart: START with A=3, B=5, then START again 4 cycles later with A=7, B=9 -> DONE rises 16 edges after the second START, Y=0x003F, with no DONE pulse from the first operation.
- Hold: after DONE with Y=0x8B47, leave START=0 for 50 cycles -> DONE stays 1 and Y stays 0x8B47.
